spi_config_master: RTL and testbench



---
 rtl/spi_config_pkg.sv | 104 ++++++++++
 rtl/spi_config_master_if.sv | 27 ++
 rtl/spi_config_master_sck_timer.sv | 32 +++
 rtl/spi_config_master.sv | 115 +++++++++++
 tb/tb_spi_config_master.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_config_pkg.sv
// Shared definitions for the FM transmitter SPI configuration link: vector
// width, field map, reset defaults and the master FSM state type. Both the
// master and the slave import this package so they agree on the bit layout.
package spi_config_pkg;

  // Total configuration vector width.
  localparam int DW = 36;

  // Field positions (LSB index) and widths inside the configuration vector.
  localparam int ACC_INC_POS      = 0;
  localparam int ACC_INC_W        = 18;
  localparam int DF_INC_COEF_POS  = 18;
  localparam int DF_INC_COEF_W    = 4;
  localparam int DF_INC_FACT_POS  = 22;
  localparam int DF_INC_FACT_W    = 2;
  localparam int DAC_ENA_POS      = 24;
  localparam int DAC_ENA_W        = 5;
  localparam int DITH_FACT_POS    = 29;
  localparam int DITH_FACT_W      = 3;
  localparam int TX_ENA_POS       = 32;
  localparam int PILOT_ENA_POS    = 33;
  localparam int MUTE_POS         = 34;
  localparam int SPI_OVERRIDE_POS = 35;

  // Slave register contents after its reset.
  localparam logic [17:0] ACC_INC_DEF      = 18'h0CCCD;
  localparam logic [3:0]  DF_INC_COEF_DEF  = 4'hC;
  localparam logic [1:0]  DF_INC_FACT_DEF  = 2'h0;
  localparam logic [4:0]  DAC_ENA_DEF      = 5'h1F;
  localparam logic [2:0]  DITH_FACT_DEF    = 3'h2;
  localparam logic        TX_ENA_DEF       = 1'b0;
  localparam logic        PILOT_ENA_DEF    = 1'b0;
  localparam logic        MUTE_DEF         = 1'b0;
  localparam logic        SPI_OVERRIDE_DEF = 1'b0;

  // Decoded view of the configuration vector.
  typedef struct packed {
    logic        spi_override;
    logic        mute;
    logic        pilot_ena;
    logic        tx_ena;
    logic [2:0]  dith_fact;
    logic [4:0]  dac_ena;
    logic [1:0]  df_inc_fact;
    logic [3:0]  df_inc_coef;
    logic [17:0] acc_inc;
  } spi_config_t;

  // Master FSM states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    TRAIL = 3'd4
  } spi_state_e;

  // Build a raw vector from decoded fields using the position constants.
  function automatic logic [DW-1:0] pack_config(input spi_config_t cfg);
    logic [DW-1:0] v;
    v = '0;
    v[ACC_INC_POS     +: ACC_INC_W]     = cfg.acc_inc;
    v[DF_INC_COEF_POS +: DF_INC_COEF_W] = cfg.df_inc_coef;
    v[DF_INC_FACT_POS +: DF_INC_FACT_W] = cfg.df_inc_fact;
    v[DAC_ENA_POS     +: DAC_ENA_W]     = cfg.dac_ena;
    v[DITH_FACT_POS   +: DITH_FACT_W]   = cfg.dith_fact;
    v[TX_ENA_POS]                       = cfg.tx_ena;
    v[PILOT_ENA_POS]                    = cfg.pilot_ena;
    v[MUTE_POS]                         = cfg.mute;
    v[SPI_OVERRIDE_POS]                 = cfg.spi_override;
    return v;
  endfunction

  // Split a raw vector into decoded fields using the position constants.
  function automatic spi_config_t unpack_config(input logic [DW-1:0] v);
    spi_config_t cfg;
    cfg.acc_inc      = v[ACC_INC_POS     +: ACC_INC_W];
    cfg.df_inc_coef  = v[DF_INC_COEF_POS +: DF_INC_COEF_W];
    cfg.df_inc_fact  = v[DF_INC_FACT_POS +: DF_INC_FACT_W];
    cfg.dac_ena      = v[DAC_ENA_POS     +: DAC_ENA_W];
    cfg.dith_fact    = v[DITH_FACT_POS   +: DITH_FACT_W];
    cfg.tx_ena       = v[TX_ENA_POS];
    cfg.pilot_ena    = v[PILOT_ENA_POS];
    cfg.mute         = v[MUTE_POS];
    cfg.spi_override = v[SPI_OVERRIDE_POS];
    return cfg;
  endfunction

  // Raw reset-default vector of the slave.
  function automatic logic [DW-1:0] default_config();
    spi_config_t cfg;
    cfg.acc_inc      = ACC_INC_DEF;
    cfg.df_inc_coef  = DF_INC_COEF_DEF;
    cfg.df_inc_fact  = DF_INC_FACT_DEF;
    cfg.dac_ena      = DAC_ENA_DEF;
    cfg.dith_fact    = DITH_FACT_DEF;
    cfg.tx_ena       = TX_ENA_DEF;
    cfg.pilot_ena    = PILOT_ENA_DEF;
    cfg.mute         = MUTE_DEF;
    cfg.spi_override = SPI_OVERRIDE_DEF;
    return pack_config(cfg);
  endfunction

endpackage

// File: rtl/spi_config_master_if.sv
// Request/response handshake and SPI pins of the configuration master,
// bundled so the controller side and the pin side connect as one port.
interface spi_config_master_if #(
  parameter int DW = spi_config_pkg::DW
);

  logic          start;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic [DW-1:0] rd_data;
  logic          spi_sck;
  logic          spi_csn;
  logic          spi_mosi;
  logic          spi_miso;

  modport master (
    input  start, wr_data, spi_miso,
    output busy, done, rd_data, spi_sck, spi_csn, spi_mosi
  );

  modport slave (
    output start, wr_data, spi_miso,
    input  busy, done, rd_data, spi_sck, spi_csn, spi_mosi
  );

endinterface

// File: rtl/spi_config_master_sck_timer.sv
// Phase timer for the SPI master: while a frame runs it counts CLK_DIV
// spi_clk cycles per FSM phase and flags the last cycle of each phase.
module spi_sck_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic spi_clk,
  input  logic rst,
  input  logic run,
  output logic phase_end
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  // Free-running modulo-CLK_DIV count while a frame is active, held at zero otherwise.
  always_ff @(posedge spi_clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!run) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign phase_end = run && (count == LAST);

endmodule

// File: rtl/spi_config_master.sv
// SPI initiator that writes a full configuration vector into the FM
// transmitter and captures the previous register contents from MISO.
// Frame: CSn low, DW SCK periods MSB first, CSn high; SCK idles low.
module spi_config_master #(
  parameter int DW      = spi_config_pkg::DW,
  parameter int CLK_DIV = 2
) (
  input  logic                 spi_clk,
  input  logic                 rst,
  spi_config_master_if.master  bus
);

  import spi_config_pkg::*;

  localparam int            BW       = $clog2(DW + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DW);

  spi_state_e    state;
  logic [DW-1:0] tx_sr;
  logic [DW-1:0] rx_sr;
  logic [BW-1:0] bit_cnt;
  logic          run;
  logic          phase_end;

  assign run = (state != IDLE);

  spi_sck_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .spi_clk   (spi_clk),
    .rst       (rst),
    .run       (run),
    .phase_end (phase_end)
  );

  // Frame sequencer: steps IDLE/LEAD/HIGH/LOW/TRAIL and drives every output from a register.
  always_ff @(posedge spi_clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      tx_sr        <= '0;
      rx_sr        <= '0;
      bit_cnt      <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.rd_data  <= '0;
      bus.spi_sck  <= 1'b0;
      bus.spi_csn  <= 1'b1;
      bus.spi_mosi <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            // MSB goes straight onto MOSI; the rest waits in tx_sr.
            tx_sr        <= bus.wr_data << 1;
            rx_sr        <= '0;
            bit_cnt      <= '0;
            bus.busy     <= 1'b1;
            bus.spi_csn  <= 1'b0;
            bus.spi_sck  <= 1'b0;
            bus.spi_mosi <= bus.wr_data[DW-1];
            state        <= LEAD;
          end
        end
        LEAD: begin
          if (phase_end) begin
            bus.spi_sck <= 1'b1;
            bit_cnt     <= BW'(1);
            state       <= HIGH;
          end
        end
        HIGH: begin
          if (phase_end) begin
            // Falling edge: present the next bit (zero after the last one).
            bus.spi_sck  <= 1'b0;
            bus.spi_mosi <= tx_sr[DW-1];
            tx_sr        <= tx_sr << 1;
            state        <= LOW;
          end
        end
        LOW: begin
          if (phase_end) begin
            // Slave drives MISO one falling edge late, so this is its bit DW-k.
            rx_sr <= {rx_sr[DW-2:0], bus.spi_miso};
            if (bit_cnt == LAST_BIT) begin
              bus.spi_csn  <= 1'b1;
              bus.spi_mosi <= 1'b0;
              state        <= TRAIL;
            end else begin
              bus.spi_sck <= 1'b1;
              bit_cnt     <= bit_cnt + BW'(1);
              state       <= HIGH;
            end
          end
        end
        TRAIL: begin
          if (phase_end) begin
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            bus.rd_data <= rx_sr;
            state       <= IDLE;
          end
        end
        default: begin
          bus.busy     <= 1'b0;
          bus.spi_sck  <= 1'b0;
          bus.spi_csn  <= 1'b1;
          bus.spi_mosi <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_config_master.sv
// Bench for spi_config_master: loopback to a behavioural configuration slave,
// scoreboard of expected rd_data / done cycle, and SPI protocol monitor on
// instances built with CLK_DIV = 2, 1 and 3.
module tb_spi_config_master;

  localparam int DW       = spi_config_pkg::DW;
  localparam int DONE_LAT = 149;

  localparam logic [DW-1:0] DEF = 36'h0_5F30_CCCD;
  localparam logic [DW-1:0] W1  = 36'h9_ABCD_1234;
  localparam logic [DW-1:0] WA  = 36'hF_0000_000F;
  localparam logic [DW-1:0] WB  = 36'h1_2345_6789;
  localparam logic [DW-1:0] WC  = 36'h0_FFFF_0000;

  typedef struct { logic [DW-1:0] rd; int cyc; } exp_t;
  typedef struct { int rises; int low; } prot_t;

  logic spi_clk = 1'b0;
  logic rst     = 1'b1;
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;

  exp_t  sb_q[$];
  prot_t prot_q[$];

  always #5 spi_clk = ~spi_clk;
  always @(posedge spi_clk) cyc <= cyc + 1;

  spi_config_master_if #(.DW(DW)) bus ();
  spi_config_master_if #(.DW(DW)) b1 ();
  spi_config_master_if #(.DW(DW)) b3 ();

  spi_config_master #(.DW(DW), .CLK_DIV(2)) u_dut (.spi_clk(spi_clk), .rst(rst), .bus(bus.master));
  spi_config_master #(.DW(DW), .CLK_DIV(1)) u_d1  (.spi_clk(spi_clk), .rst(rst), .bus(b1.master));
  spi_config_master #(.DW(DW), .CLK_DIV(3)) u_d3  (.spi_clk(spi_clk), .rst(rst), .bus(b3.master));

  assign b1.spi_miso = 1'b0;
  assign b3.spi_miso = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural configuration slave ----------------
  logic [DW-1:0] slv_cfg  = DEF;
  logic [DW-1:0] slv_in   = '0;
  logic [DW-1:0] slv_out  = '0;
  int            slv_rises = 0;
  logic          slv_miso = 1'b0;

  assign bus.spi_miso = slv_miso;

  initial forever begin
    @(negedge bus.spi_csn);
    slv_out   = slv_cfg;
    slv_rises = 0;
  end
  initial forever begin
    @(posedge bus.spi_sck);
    if (bus.spi_csn === 1'b0) begin
      slv_in = {slv_in[DW-2:0], bus.spi_mosi};
      slv_rises++;
    end
  end
  initial forever begin
    @(negedge bus.spi_sck);
    if (bus.spi_csn === 1'b0) begin
      slv_miso = slv_out[DW-1];
      slv_out  = slv_out << 1;
    end
  end
  initial forever begin
    @(posedge bus.spi_csn);
    if (slv_rises == DW) slv_cfg = slv_in;
  end

  // ---------------- monitors ----------------
  int   sel = 0;
  logic prot_en = 1'b0;
  logic p_sck, p_csn, p_mosi, p_done;
  assign p_sck  = (sel == 1) ? b1.spi_sck  : (sel == 3) ? b3.spi_sck  : bus.spi_sck;
  assign p_csn  = (sel == 1) ? b1.spi_csn  : (sel == 3) ? b3.spi_csn  : bus.spi_csn;
  assign p_mosi = (sel == 1) ? b1.spi_mosi : (sel == 3) ? b3.spi_mosi : bus.spi_mosi;
  assign p_done = (sel == 1) ? b1.done     : (sel == 3) ? b3.done     : bus.done;

  // Scoreboard: each done of the main instance pops one expected frame.
  initial forever begin
    exp_t e;
    @(negedge spi_clk);
    if (bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: done seen at cycle %0d with nothing expected", cyc);
      end else begin
        e = sb_q.pop_front();
        check("rd_data", bus.rd_data, e.rd);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Protocol monitor on the selected instance.
  int   rise_cnt = 0, low_cnt = 0, mosi_err = 0, idle_sck_err = 0;
  logic prev_sck = 1'b0, prev_csn = 1'b1, prev_mosi = 1'b0;
  initial forever begin
    prot_t pe;
    @(negedge spi_clk);
    if (prot_en) begin
      if (prev_csn && !p_csn) begin
        rise_cnt = 0; low_cnt = 0; mosi_err = 0;
      end
      if (!p_csn) begin
        low_cnt++;
        if (!prev_sck && p_sck) rise_cnt++;
        if (p_sck && !prev_csn && (p_mosi !== prev_mosi)) mosi_err++;
      end else if (p_sck) begin
        idle_sck_err++;
      end
      if (!prev_csn && p_csn) begin
        if (prot_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_frame: csn frame ended with nothing expected (sel %0d)", sel);
        end else begin
          pe = prot_q.pop_front();
          check("sck_rises", rise_cnt, pe.rises);
          check("csn_low_cycles", low_cnt, pe.low);
          check("mosi_stable_high", mosi_err, 0);
        end
      end
    end
    prev_sck  = p_sck;
    prev_csn  = p_csn;
    prev_mosi = p_mosi;
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_frame(input logic [DW-1:0] wr, input logic [DW-1:0] exp_rd);
    bus.wr_data = wr;
    bus.start   = 1'b1;
    sb_q.push_back('{exp_rd, cyc + DONE_LAT});
    @(negedge spi_clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    @(negedge spi_clk);
    while (p_done !== 1'b1 && n < 400) begin
      @(negedge spi_clk);
      n++;
    end
    checks++;
    if (p_done !== 1'b1) begin
      errors++;
      $display("FAIL %s: done %b after %0d cycles, required 1", tag, p_done, n);
    end
  endtask

  task automatic aux_frame(input int which);
    sel     = which;
    prot_en = 1'b1;
    if (which == 1) begin
      prot_q.push_back('{36, 73});
      b1.wr_data = 36'hC_3A5F_0F96;
      b1.start   = 1'b1;
    end else begin
      prot_q.push_back('{36, 219});
      b3.wr_data = 36'h6_9C3A_5A01;
      b3.start   = 1'b1;
    end
    @(negedge spi_clk);
    b1.start = 1'b0;
    b3.start = 1'b0;
    wait_done(which == 1 ? "d1_frame" : "d3_frame");
    @(negedge spi_clk);
    prot_en = 1'b0;
    sel     = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    spi_config_pkg::spi_config_t f;
    int n, gap, rises;
    logic prev;
    bus.start = 1'b0; bus.wr_data = '0;
    b1.start  = 1'b0; b1.wr_data  = '0;
    b3.start  = 1'b0; b3.wr_data  = '0;

    repeat (3) @(negedge spi_clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_sck", bus.spi_sck, 0);
    check("rst_csn", bus.spi_csn, 1);
    check("rst_mosi", bus.spi_mosi, 0);
    rst = 1'b0;
    @(negedge spi_clk);

    // Frame 1: write W1, read slave defaults; protocol checked at CLK_DIV=2.
    prot_en = 1'b1;
    prot_q.push_back('{36, 146});
    start_frame(W1, DEF);
    wait_done("f1");
    prot_en = 1'b0;
    f = spi_config_pkg::unpack_config(slv_cfg);
    check("slave_acc_inc_f1", f.acc_inc, 18'h11234);

    // Frame 2: write defaults back, read W1.
    start_frame(DEF, W1);
    wait_done("f2");
    f = spi_config_pkg::unpack_config(slv_cfg);
    check("slave_acc_inc_f2", f.acc_inc, 18'h0CCCD);
    check("slave_dac_ena_f2", f.dac_ena, 5'h1F);
    check("slave_dith_fact_f2", f.dith_fact, 3'h2);

    // Protocol at CLK_DIV=1 and CLK_DIV=3.
    aux_frame(1);
    aux_frame(3);

    // Back-to-back: start held; wr_data changed mid-frame feeds only the next frame.
    bus.wr_data = WA;
    bus.start   = 1'b1;
    sb_q.push_back('{DEF, cyc + DONE_LAT});
    sb_q.push_back('{WA, cyc + 2 * DONE_LAT});
    repeat (5) @(negedge spi_clk);
    bus.wr_data = WB;
    n = 0;
    while (bus.spi_csn == 1'b0 && n < 400) begin @(negedge spi_clk); n++; end
    gap = 0;
    while (bus.spi_csn == 1'b1 && gap < 20) begin @(negedge spi_clk); gap++; end
    bus.start = 1'b0;
    // TRAIL (2 cycles) plus the one IDLE cycle in which done and start coincide.
    check("csn_gap_b2b", gap, 3);
    check("busy_b2b", bus.busy, 1);
    wait_done("f4");

    // Start pulsed while busy must be ignored.
    start_frame(WC, WB);
    repeat (40) @(negedge spi_clk);
    bus.wr_data = 36'hA_AAAA_AAAA;
    bus.start   = 1'b1;
    @(negedge spi_clk);
    bus.start = 1'b0;
    wait_done("f5");
    repeat (160) @(negedge spi_clk);
    check("no_extra_frame", sb_q.size(), 0);

    // Reset at SCK rising edge 10 abandons the frame.
    bus.wr_data = 36'h5_5555_5555;
    bus.start   = 1'b1;
    @(negedge spi_clk);
    bus.start = 1'b0;
    n = 0; rises = 0; prev = 1'b0;
    while (rises < 10 && n < 100) begin
      @(negedge spi_clk);
      if (bus.spi_sck && !prev) rises++;
      prev = bus.spi_sck;
      n++;
    end
    check("edges_before_rst", rises, 10);
    #1 rst = 1'b1;
    #1;
    check("midrst_csn", bus.spi_csn, 1);
    check("midrst_sck", bus.spi_sck, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_rd_data", bus.rd_data, 0);
    check("midrst_mosi", bus.spi_mosi, 0);
    @(negedge spi_clk);
    rst = 1'b0;
    repeat (200) @(negedge spi_clk);

    // Normal frame after reset; slave still holds WC.
    start_frame(36'h3_C3C3_C3C3, WC);
    wait_done("f7");
    repeat (4) @(negedge spi_clk);

    check("sb_empty", sb_q.size(), 0);
    check("prot_empty", prot_q.size(), 0);
    check("sck_idle_toggle", idle_sck_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
